// File: rtl/column_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : column_stream_source
// Purpose  : Bring-up column-record transmitter. On a frame trigger it streams
//            one 38-bit record per screen column over valid/ready/last, using
//            one of four synthetic wall patterns latched per frame.
// Revision : 1.0 - initial release
// ============================================================================
module column_stream_source #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int FLAT_HEIGHT   = 120,
    parameter int PHASE_STEP    = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [1:0]  mode_in,
    input  logic        col_tready_in,
    output logic        col_tvalid_out,
    output logic [37:0] col_tdata_out,
    output logic        col_tlast_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        overrun_out
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // 10-bit copies of the geometry so column arithmetic never wraps at 9 bits
    localparam logic [9:0] WIDTH_C = 10'(SCREEN_WIDTH);
    localparam logic [9:0] HALF_C  = 10'(SCREEN_WIDTH / 2);
    localparam logic [9:0] LAST_C  = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0] HMAX_C  = 10'(SCREEN_HEIGHT);
    localparam logic [9:0] FLAT_C  = 10'(FLAT_HEIGHT);
    localparam logic [9:0] STEP_C  = 10'(PHASE_STEP);
    localparam logic [8:0] LAST_H  = 9'(SCREEN_WIDTH - 1);

    state_t      state;
    state_t      next_state;
    logic [8:0]  hcount;
    logic [8:0]  next_hcount;
    logic [8:0]  phase;
    logic [8:0]  next_phase;
    logic [1:0]  mode;
    logic [1:0]  next_mode;
    logic [9:0]  phase_sum;
    logic        handshake;
    logic        final_hs;
    logic        next_done;
    logic        next_overrun;
    logic [37:0] next_record;

    // Build one column record for column h, pattern m and scroll phase p
    function automatic logic [37:0] make_record(
        input logic [8:0] h,
        input logic [1:0] m,
        input logic [8:0] p
    );
        logic [9:0]  s;
        logic [9:0]  tri_v;
        logic [9:0]  height;
        logic        wall_type;
        logic [3:0]  map_data;
        logic [15:0] wall_x;
        s = {1'b0, h} + {1'b0, p};
        if (s >= WIDTH_C) begin
            s = s - WIDTH_C;
        end
        tri_v     = (s < HALF_C) ? s : (LAST_C - s);
        height    = FLAT_C;
        wall_type = 1'b0;
        map_data  = 4'd1;
        wall_x    = 16'h0000;
        case (m)
            2'd1: begin
                height    = {2'b00, h[8:1]};
                wall_type = h[0];
                map_data  = h[8:5];
                wall_x    = {h[3:0], 12'h000};
            end
            2'd2: begin
                height    = h[4] ? 10'd200 : 10'd40;
                wall_type = h[4];
                map_data  = h[8:5];
                wall_x    = {h[3:0], 12'h000};
            end
            2'd3: begin
                height    = 10'd40 + tri_v;
                wall_type = s[5];
                map_data  = s[8:5];
                wall_x    = {s[3:0], 12'h000};
            end
            default: begin
                height    = FLAT_C;
            end
        endcase
        if (height > HMAX_C) begin
            height = HMAX_C;
        end
        return {h, height[7:0], wall_type, map_data, wall_x};
    endfunction

    assign handshake      = col_tvalid_out && col_tready_in;
    assign final_hs       = handshake && (hcount == LAST_H);
    assign col_tvalid_out = (state == STREAM);
    assign busy_out       = (state == STREAM);

    // Next-state, next-column and event decode; record is formed from next values
    always_comb begin
        next_state   = state;
        next_hcount  = hcount;
        next_mode    = mode;
        next_phase   = phase;
        next_done    = 1'b0;
        next_overrun = 1'b0;
        phase_sum    = {1'b0, phase} + STEP_C;
        case (state)
            IDLE: begin
                if (start_in) begin
                    next_state  = STREAM;
                    next_hcount = 9'd0;
                    next_mode   = mode_in;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    next_phase = 9'((phase_sum >= WIDTH_C) ? (phase_sum - WIDTH_C) : phase_sum);
                    next_done  = 1'b1;
                    next_hcount = 9'd0;
                    if (start_in) begin
                        next_mode = mode_in;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        next_hcount = hcount + 9'd1;
                    end
                    next_overrun = start_in;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        next_record = make_record(next_hcount, next_mode, next_phase);
    end

    // State register
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Column counter, frame context and registered record outputs
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount         <= 9'd0;
            mode           <= 2'd0;
            phase          <= 9'd0;
            col_tdata_out  <= 38'd0;
            col_tlast_out  <= 1'b0;
            frame_done_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            hcount         <= next_hcount;
            mode           <= next_mode;
            phase          <= next_phase;
            col_tdata_out  <= (next_state == STREAM) ? next_record : 38'd0;
            col_tlast_out  <= (next_state == STREAM) && (next_hcount == LAST_H);
            frame_done_out <= next_done;
            overrun_out    <= next_overrun;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_column_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_stream_source
// Purpose  : Self-checking bench for column_stream_source: reference model of
//            the record patterns plus a table of hand-computed columns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_stream_source;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int FLAT = 120;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode_in;
    logic        col_tready;
    logic        tvalid;
    logic [37:0] tdata;
    logic        tlast;
    logic        busy;
    logic        done;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int model_phase = 0;
    bit found;

    logic [37:0] cap [0:7][0:319];

    typedef struct {
        int slot;
        int h;
        int ht;
        int wt;
        int md;
        int wx;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    column_stream_source #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .FLAT_HEIGHT  (FLAT),
        .PHASE_STEP   (STEP)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .start_in      (start),
        .mode_in       (mode_in),
        .col_tready_in (col_tready),
        .col_tvalid_out(tvalid),
        .col_tdata_out (tdata),
        .col_tlast_out (tlast),
        .busy_out      (busy),
        .frame_done_out(done),
        .overrun_out   (ovr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Record expected for column h under pattern m with scroll phase ph
    function automatic logic [37:0] ref_rec(input int h, input int m, input int ph);
        int s, tri_v, ht, wt, md, wx;
        s = (h + ph) % W;
        tri_v = (s < W / 2) ? s : (W - 1 - s);
        case (m)
            1: begin ht = h / 2; wt = h % 2; md = h / 32; wx = (h % 16) * 4096; end
            2: begin wt = (h / 16) % 2; ht = (wt != 0) ? 200 : 40; md = h / 32; wx = (h % 16) * 4096; end
            3: begin ht = 40 + tri_v; wt = (s / 32) % 2; md = s / 32; wx = (s % 16) * 4096; end
            default: begin ht = FLAT; wt = 0; md = 1; wx = 0; end
        endcase
        if (ht > H) ht = H;
        return {9'(h), 8'(ht), 1'(wt), 4'(md), 16'(wx)};
    endfunction

    // Start a frame (optionally an ignored start at ovr_h, or a chained start
    // on the final handshake) and check every cycle against the model.
    task automatic run_frames(input int mode, input bit rnd, input int ovr_h,
                              input int chain_mode, input int slot);
        bit          m_stream = 0;
        int          m_h = 0;
        int          m_mode = mode;
        int          frames_left;
        bit          exp_done = 0;
        bit          exp_ovr = 0;
        bit          prev_stall = 0;
        logic [37:0] prev_data = 38'd0;
        bit          ovr_fired = 0;
        int          done_it = -1;
        int          done_cnt = 0;
        int          ovr_cnt = 0;
        int          tail = 0;
        int          frame_idx = 0;
        bit          finished = 0;
        bit          st, hs, rdy;
        frames_left = (chain_mode >= 0) ? 2 : 1;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            check("valid", tvalid, m_stream);
            check("busy", busy, m_stream);
            check("frame_done", done, exp_done);
            check("overrun", ovr, exp_ovr);
            if (done) begin
                done_cnt++;
                if (done_it < 0) done_it = it;
            end
            if (ovr) ovr_cnt++;
            if (m_stream) begin
                check("tdata", tdata, ref_rec(m_h, m_mode, model_phase));
                check("tlast", tlast, (m_h == W - 1));
            end
            if (prev_stall) check("hold_data", tdata, prev_data);
            if (frames_left == 0 && !exp_done) begin
                tail++;
                if (tail >= 3) begin
                    finished = 1;
                    break;
                end
            end
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            st = 0;
            if (it == 0) begin
                st = 1;
                mode_in = 2'(mode);
            end else if (m_stream && m_h == ovr_h && !ovr_fired) begin
                st = 1;
                ovr_fired = 1;
                mode_in = 2'($urandom_range(0, 3));
            end else if (chain_mode >= 0 && frames_left == 2 && m_stream && m_h == W - 1 && rdy) begin
                st = 1;
                mode_in = 2'(chain_mode);
            end
            start = st;
            col_tready = rdy;
            hs = m_stream && rdy;
            exp_done = hs && (m_h == W - 1);
            exp_ovr = st && m_stream && !exp_done;
            prev_stall = m_stream && !rdy;
            prev_data = tdata;
            if (hs) begin
                if (slot >= 0 && frame_idx == 0) cap[slot][m_h] = tdata;
                if (m_h == W - 1) begin
                    model_phase = (model_phase + STEP) % W;
                    frames_left--;
                    frame_idx++;
                    m_h = 0;
                    if (st) m_mode = int'(mode_in);
                    else m_stream = 0;
                end else begin
                    m_h++;
                end
            end else if (!m_stream && st) begin
                m_stream = 1;
                m_h = 0;
                m_mode = int'(mode_in);
            end
        end
        start = 0;
        check("frame_timeout", finished, 1'b1);
        check("done_count", done_cnt, (chain_mode >= 0) ? 2 : 1);
        check("overrun_count", ovr_cnt, (ovr_h >= 0) ? 1 : 0);
        if (!rnd && chain_mode < 0) check("done_latency", done_it, 321);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode_in = 2'd0;
        col_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", tvalid, 1'b0);
        check("rst_tdata", tdata, 38'd0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overrun", ovr, 1'b0);
        rst = 1'b0;

        run_frames(3, 1'b0, -1, -1, 0);
        run_frames(3, 1'b0, -1, -1, 1);
        run_frames(3, 1'b0, -1, -1, 2);
        run_frames(3, 1'b0, -1, -1, 3);
        run_frames(1, 1'b1, -1, -1, 4);
        run_frames(0, 1'b0, -1, -1, 5);
        run_frames(2, 1'b1, -1, -1, 6);
        run_frames(0, 1'b0, 50, -1, -1);
        run_frames(0, 1'b0, -1, 1, -1);

        // Reset in the middle of a stalled frame
        @(negedge clk);
        start = 1'b1;
        mode_in = 2'd1;
        col_tready = 1'b1;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (tvalid && tdata[37:29] == 9'd200) begin
                col_tready = 1'b0;
                rst = 1'b1;
                found = 1;
                break;
            end
        end
        check("reach_h200", found, 1'b1);
        @(negedge clk);
        check("mid_rst_valid", tvalid, 1'b0);
        check("mid_rst_tdata", tdata, 38'd0);
        check("mid_rst_tlast", tlast, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_overrun", ovr, 1'b0);
        rst = 1'b0;
        model_phase = 0;
        run_frames(3, 1'b0, -1, -1, 7);

        tbl[0]  = '{5,   0, 120, 0, 1, 'h0000};
        tbl[1]  = '{5, 319, 120, 0, 1, 'h0000};
        tbl[2]  = '{4, 100,  50, 0, 3, 'h4000};
        tbl[3]  = '{4, 319, 159, 1, 9, 'hF000};
        tbl[4]  = '{6,  16, 200, 1, 0, 'h0000};
        tbl[5]  = '{6,  15,  40, 0, 0, 'hF000};
        tbl[6]  = '{0, 159, 199, 0, 4, 'hF000};
        tbl[7]  = '{0, 160, 199, 1, 5, 'h0000};
        tbl[8]  = '{0, 319,  40, 1, 9, 'hF000};
        tbl[9]  = '{1,   0,  44, 0, 0, 'h4000};
        tbl[10] = '{2, 315,  43, 0, 0, 'h3000};
        tbl[11] = '{3,   0,  52, 0, 0, 'hC000};
        tbl[12] = '{7,   0,  40, 0, 0, 'h0000};
        tbl[13] = '{7, 200, 159, 0, 6, 'h8000};
        for (int i = 0; i < 14; i++) begin
            check($sformatf("table_%0d", i), cap[tbl[i].slot][tbl[i].h],
                  {9'(tbl[i].h), 8'(tbl[i].ht), 1'(tbl[i].wt), 4'(tbl[i].md), 16'(tbl[i].wx)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/column_stream_source.md
# column_stream_source

Bring-up transmitter for the DDA-out column stream. On each frame trigger it emits one 38-bit column record per screen column (hcount 0..SCREEN_WIDTH-1) on a valid/ready/last interface identical to the DDA module's output. It drives the DDA-out FIFO sender port in place of the DDA, so the transformation module and frame buffer can be exercised without ray calculation or DDA. Synthetic wall patterns are selectable per frame, including one animated pattern.

## Interface
Parameters:
- SCREEN_WIDTH, 320, columns per frame; hcount field is 9 bits.
- SCREEN_HEIGHT, 240, maximum line height; must be ≤ 255.
- FLAT_HEIGHT, 120, line height for mode 0.
- PHASE_STEP, 4, columns the mode-3 pattern scrolls per completed frame.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_in  in  1  synchronous, active-high reset.
- start_in  in  1  frame trigger pulse, normally new_frame.
- mode_in  in  2  pattern select, sampled on accepted start.
- col_tready_in  in  1  FIFO ready.
- col_tvalid_out  out  1  record valid.
- col_tdata_out  out  38  record: [37:29] hcount, [28:21] line_height, [20] wall_type, [19:16] map_data, [15:0] wallX.
- col_tlast_out  out  1  high with the hcount = SCREEN_WIDTH-1 record.
- busy_out  out  1  frame in progress.
- frame_done_out  out  1  one-cycle pulse after the final handshake.
- overrun_out  out  1  one-cycle pulse when start_in is ignored.

## Operation
- States are IDLE and STREAM.
- IDLE + start_in: latch mode_in, set hcount=0, go to STREAM.
- STREAM: a handshake is col_tvalid_out && col_tready_in.
  - On a handshake with hcount < SCREEN_WIDTH-1, increment hcount.
  - On the handshake with hcount = SCREEN_WIDTH-1:
    - advance phase = (phase + PHASE_STEP) mod SCREEN_WIDTH;
    - pulse frame_done_out;
    - go to IDLE.
- start_in in STREAM, except in the final-handshake cycle, is ignored and pulses overrun_out.
- start_in coinciding with the final handshake is accepted:
  - hcount=0 and a freshly latched mode next cycle;
  - stay in STREAM with valid held high.
- Records are formed from the registered hcount h. All fields are registered outputs.
  - Mode 0 FLAT:
    - height = FLAT_HEIGHT; wall_type = 0; map_data = 1; wallX = 0.
  - Mode 1 RAMP:
    - height = h[8:1] (0..159); wall_type = h[0]; map_data = h[8:5]; wallX = {h[3:0], 12'h000}.
  - Mode 2 STRIPES:
    - height = h[4] ? 200 : 40; wall_type = h[4]; map_data = h[8:5]; wallX = {h[3:0], 12'h000}.
  - Mode 3 SCROLL:
    - s = h + phase; if s ≥ SCREEN_WIDTH, subtract SCREEN_WIDTH. Use a 10-bit intermediate, no 9-bit wrap.
    - tri = (s < SCREEN_WIDTH/2) ? s : SCREEN_WIDTH-1-s.
    - height = 40 + tri.
    - wall_type = s[5]; map_data = s[8:5]; wallX = {s[3:0], 12'h000}.
- All heights are clamped to SCREEN_HEIGHT.
- phase changes only at frame end, so it is constant within a frame.

## Timing
- Reset values: col_tvalid_out=0, col_tdata_out=0, col_tlast_out=0, busy_out=0, frame_done_out=0, overrun_out=0. Internally, phase=0, hcount=0, state IDLE.
- Reset mid-frame aborts immediately; no partial-frame completion.
- Start latency: start_in in cycle N gives col_tvalid_out=1 with hcount 0 in cycle N+1.
- Throughput: one record per cycle while col_tready_in stays high. A full frame takes SCREEN_WIDTH cycles.
- Hold rule: col_tvalid_out never drops without a handshake. col_tdata_out and col_tlast_out are stable while valid && !ready.
- The next record appears the cycle after its handshake.
- busy_out equals STREAM.
- After the final handshake, col_tvalid_out=0 the next cycle unless a coincident start was accepted.
- frame_done_out is high in the cycle after the final handshake.
- overrun_out is high in the cycle after the ignored start_in.

## Test plan
- Mode 0, ready always 1, one start:
  - 320 records with hcount 0..319, each tdata = {h, 8'd120, 1'b0, 4'd1, 16'h0000};
  - tlast only at h=319;
  - frame_done_out pulse at cycle 321 after start.
- Mode 1, ready toggling pseudo-randomly:
  - data held stable during stalls, no lost or duplicated hcounts;
  - h=100 gives height 50, wall_type 0, map_data 3, wallX 16'h4000.
- Mode 3, four consecutive frames:
  - phase is 0, 4, 8, 12;
  - frame 2 (phase 8) at h=315: s=3, height 43;
  - frame 0 at h=159 gives height 199; h=160 gives height 199; h=319 gives height 40.
- start_in pulsed at h=50:
  - overrun_out pulse; stream continues unchanged;
  - exactly one frame_done_out.
- start_in on the final-handshake cycle:
  - the next cycle shows valid=1 and hcount 0 with the new mode;
  - no valid gap.
- rst_in at h=200 with ready=0:
  - next cycle all outputs 0 and busy_out=0;
  - a following start begins at h=0 with phase 0.
